// File: rtl/hoplite_axis_egress.sv
// Ejection-side bridge from a Hoplite torus node to a 64-bit AXI4-Stream master.
// A first-word-fall-through FIFO absorbs ejections; overflow drops are counted.
module hoplite_axis_egress #(
    parameter int D_W   = 32,
    parameter int X_AW  = 1,
    parameter int Y_AW  = 1,
    parameter int X_POS = 0,
    parameter int Y_POS = 0,
    parameter int DEPTH = 16,
    localparam int P_W  = D_W + X_AW + Y_AW
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [P_W-1:0]           in_pkt,
    input  logic                     in_vld,
    output logic                     axis_m_tvalid,
    input  logic                     axis_m_tready,
    output logic [63:0]              axis_m_tdata,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              drop_cnt,
    output logic [15:0]              misroute_cnt,
    output logic                     overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    if (P_W > 64) begin : g_pw_check
        $error("hoplite_axis_egress: packet width P_W exceeds 64 bits");
    end
    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
        $error("hoplite_axis_egress: DEPTH must be a power of two >= 2");
    end

    typedef enum logic {
        ST_OK  = 1'b0,
        ST_OVF = 1'b1
    } state_e;

    logic [P_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      drop_q, drop_d;
    logic [15:0]      mis_q, mis_d;
    state_e           state_q, state_d;

    logic full_s, empty_s, pop_s, push_s, drop_s, misroute_s;

    // Handshake decode: full/empty from the extra pointer MSB, push may reuse a slot freed by a pop.
    always_comb begin
        empty_s    = (wr_ptr_q == rd_ptr_q);
        full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s      = !empty_s && axis_m_tready;
        push_s     = in_vld && (!full_s || pop_s);
        drop_s     = in_vld && full_s && !pop_s;
        misroute_s = (in_pkt[X_AW-1:0] != X_AW'(X_POS)) ||
                     (in_pkt[X_AW+Y_AW-1:X_AW] != Y_AW'(Y_POS));
    end

    // Next-state for pointers and saturating counters.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = drop_q;
        mis_d    = mis_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (drop_s && (drop_q != 32'hFFFF_FFFF)) begin
            drop_d = drop_q + 32'd1;
        end else begin
            drop_d = drop_q;
        end
        if (push_s && misroute_s && (mis_q != 16'hFFFF)) begin
            mis_d = mis_q + 16'd1;
        end else begin
            mis_d = mis_q;
        end
    end

    // Overflow status FSM: sticky until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OK: begin
                if (drop_s) begin
                    state_d = ST_OVF;
                end else begin
                    state_d = ST_OK;
                end
            end
            ST_OVF:  state_d = ST_OVF;
            default: state_d = ST_OK;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 32'd0;
            mis_q    <= 16'd0;
            state_q  <= ST_OK;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
            mis_q    <= mis_d;
            state_q  <= state_d;
        end
    end

    // Payload storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge ap_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_pkt;
        end
    end

    assign axis_m_tvalid = !empty_s;
    assign axis_m_tdata  = 64'(mem_q[rd_ptr_q[AW-1:0]]);
    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign drop_cnt      = drop_q;
    assign misroute_cnt  = mis_q;
    assign overflow      = (state_q == ST_OVF);

endmodule

// File: tb/tb_hoplite_axis_egress.sv
// Scoreboard bench for hoplite_axis_egress: a queue model predicts every beat,
// occupancy, drop/misroute counts and the sticky overflow flag.
module tb_hoplite_axis_egress;

    localparam int D_W   = 32;
    localparam int X_AW  = 1;
    localparam int Y_AW  = 1;
    localparam int X_POS = 1;
    localparam int Y_POS = 0;
    localparam int DEPTH = 16;
    localparam int P_W   = D_W + X_AW + Y_AW;

    logic                   ap_clk;
    logic                   ap_rst_n;
    logic [P_W-1:0]         in_pkt;
    logic                   in_vld;
    logic                   axis_m_tvalid;
    logic                   axis_m_tready;
    logic [63:0]            axis_m_tdata;
    logic [$clog2(DEPTH):0] occupancy;
    logic [31:0]            drop_cnt;
    logic [15:0]            misroute_cnt;
    logic                   overflow;

    hoplite_axis_egress #(
        .D_W(D_W), .X_AW(X_AW), .Y_AW(Y_AW),
        .X_POS(X_POS), .Y_POS(Y_POS), .DEPTH(DEPTH)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .in_pkt(in_pkt),
        .in_vld(in_vld),
        .axis_m_tvalid(axis_m_tvalid),
        .axis_m_tready(axis_m_tready),
        .axis_m_tdata(axis_m_tdata),
        .occupancy(occupancy),
        .drop_cnt(drop_cnt),
        .misroute_cnt(misroute_cnt),
        .overflow(overflow)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int          n_tests;
    int          n_fail;
    logic [63:0] exp_q[$];
    logic [31:0] exp_drop;
    logic [15:0] exp_mis;
    logic        exp_ovf;
    int          delivered;
    logic        prev_stall;
    logic [63:0] prev_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [P_W-1:0] mk(input logic [31:0] payload, input logic x, input logic y);
        return {payload, y, x};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        exp_drop   = 32'd0;
        exp_mis    = 16'd0;
        exp_ovf    = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 64'd0;
    endtask

    task automatic check_status(input string tag);
        check_val({tag, ".occ"},  64'(occupancy),    64'(exp_q.size()));
        check_val({tag, ".drop"}, 64'(drop_cnt),     64'(exp_drop));
        check_val({tag, ".mis"},  64'(misroute_cnt), 64'(exp_mis));
        check_val({tag, ".ovf"},  64'(overflow),     64'(exp_ovf));
    endtask

    // Called at a negedge: drive one cycle of inputs, predict the coming edge, advance to next negedge.
    task automatic cyc(input logic vld, input logic [P_W-1:0] pkt, input logic rdy, input string tag);
        logic full_m, pop_m;
        in_vld        = vld;
        in_pkt        = pkt;
        axis_m_tready = rdy;
        check_val({tag, ".tvalid"}, 64'(axis_m_tvalid), 64'(exp_q.size() != 0));
        if (prev_stall) begin
            check_val({tag, ".stable"}, axis_m_tdata, prev_data);
        end
        full_m = (exp_q.size() == DEPTH);
        pop_m  = (exp_q.size() != 0) && rdy;
        prev_stall = (exp_q.size() != 0) && !rdy;
        prev_data  = axis_m_tdata;
        if (pop_m) begin
            check_val({tag, ".tdata"}, axis_m_tdata, exp_q.pop_front());
            delivered++;
        end
        if (vld) begin
            if (full_m && !pop_m) begin
                exp_drop = exp_drop + 32'd1;
                exp_ovf  = 1'b1;
            end else begin
                exp_q.push_back(64'(pkt));
                if ((pkt[0] != 1'(X_POS)) || (pkt[1] != 1'(Y_POS))) begin
                    exp_mis = exp_mis + 16'd1;
                end
            end
        end
        @(negedge ap_clk);
        check_status(tag);
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        in_vld   = 1'b0;
        in_pkt   = '0;
        axis_m_tready = 1'b0;
        model_clear();
        repeat (2) @(negedge ap_clk);
        check_val("rst_in.tvalid", 64'(axis_m_tvalid), 64'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check_val("rst.tvalid", 64'(axis_m_tvalid), 64'd0);
        check_status("rst");
    endtask

    initial begin
        logic [P_W-1:0] p;
        n_tests   = 0;
        n_fail    = 0;
        delivered = 0;
        do_reset();

        // Single packet at own address.
        cyc(1'b1, mk(32'hDEAD_BEEF, 1'b1, 1'b0), 1'b1, "single_push");
        check_val("single.occ1", 64'(occupancy), 64'd1);
        cyc(1'b0, '0, 1'b1, "single_pop");
        check_val("single.occ0", 64'(occupancy), 64'd0);
        cyc(1'b0, '0, 1'b1, "single_idle");

        // Back-pressure fill: 20 pushes into 16 slots.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, mk(32'h1000 + 32'(i), 1'b1, 1'b0), 1'b0, "fill");
        end
        check_val("fill.occ16", 64'(occupancy), 64'd16);
        check_val("fill.drop4", 64'(drop_cnt), 64'd4);
        check_val("fill.ovf",   64'(overflow), 64'd1);

        // Full with simultaneous pop: push accepted, occupancy unchanged.
        cyc(1'b1, mk(32'h2000, 1'b1, 1'b0), 1'b1, "fullpop");
        check_val("fullpop.occ16", 64'(occupancy), 64'd16);
        check_val("fullpop.drop4", 64'(drop_cnt), 64'd4);
        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, '0, 1'b1, "drain");
        end
        check_val("drain.ovf_sticky", 64'(overflow), 64'd1);

        // Misroute: 3 to (0,0), 2 to own (1,0).
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, mk(32'h3000 + 32'(i), (i >= 3) ? 1'b1 : 1'b0, 1'b0), 1'b1, "misroute");
        end
        cyc(1'b0, '0, 1'b1, "misroute_tail");
        check_val("misroute.cnt3", 64'(misroute_cnt), 64'd3);

        // Random stall stability with 200 packets and 50% tready.
        do_reset();
        delivered = 0;
        for (int i = 0; i < 200; i++) begin
            p = {32'($urandom), 2'($urandom_range(0, 3))};
            cyc(1'b1, p, 1'($urandom_range(0, 1)), "rand");
        end
        for (int i = 0; i < DEPTH + 4; i++) begin
            cyc(1'b0, '0, 1'b1, "rand_drain");
        end
        check_val("rand.conserve", 64'(drop_cnt) + 64'(delivered), 64'd200);

        // Async reset mid-burst with 7 entries buffered.
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, mk(32'h4000 + 32'(i), 1'b1, 1'b0), 1'b0, "burst");
        end
        check_val("burst.occ7", 64'(occupancy), 64'd7);
        #2 ap_rst_n = 1'b0;
        #1;
        check_val("async.tvalid", 64'(axis_m_tvalid), 64'd0);
        check_val("async.occ",    64'(occupancy), 64'd0);
        model_clear();
        in_vld = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check_status("post_rst");
        cyc(1'b1, mk(32'h5555_AAAA, 1'b1, 1'b0), 1'b1, "after_push");
        cyc(1'b0, '0, 1'b1, "after_pop");
        cyc(1'b0, '0, 1'b1, "after_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
